reg_share_arbiter: RTL and testbench

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter.sv | 113 +++++++++++
 tb/tb_reg_share_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - four-requester arbiter guarding one shared 4-bit register
// Rotating-priority grant, one registered write per grant, forced release after TIMEOUT hold cycles.
module reg_share_arbiter #(
  parameter int TIMEOUT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] data_in,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [3:0]  q,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  localparam logic [2:0] TIMEOUT_C = 3'(TIMEOUT);

  state_t      state, state_n;
  logic [1:0]  ptr, ptr_n, w, w_n, winner;
  logic [2:0]  cnt, cnt_n;
  logic [3:0]  gnt_n, ack_n, q_n;
  logic        timeout_n;
  logic        req_w;

  assign req_w = req[w];
  assign busy  = (state != IDLE);

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      w       <= 2'd0;
      cnt     <= 3'd0;
      gnt     <= 4'd0;
      ack     <= 4'd0;
      q       <= 4'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      w       <= w_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      ack     <= ack_n;
      q       <= q_n;
      timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req != 4'd0) state_n = GRANT;
      GRANT:   state_n = req_w ? HOLD : IDLE;
      HOLD:    if (!req_w || cnt == TIMEOUT_C) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; ack defaults low so it pulses for one cycle.
  always_comb begin
    ptr_n     = ptr;
    w_n       = w;
    cnt_n     = cnt;
    gnt_n     = gnt;
    ack_n     = 4'd0;
    q_n       = q;
    timeout_n = timeout;
    case (state)
      IDLE: begin
        gnt_n = 4'd0;
        if (req != 4'd0) begin
          w_n   = winner;
          gnt_n = 4'b0001 << winner;
        end
      end
      GRANT: begin
        if (req_w) begin
          q_n   = data_in[{w, 2'b00} +: 4];
          ack_n = 4'b0001 << w;
          cnt_n = 3'd0;
        end else begin
          gnt_n = 4'd0;
        end
      end
      HOLD: begin
        if (!req_w) begin
          gnt_n = 4'd0;
          ptr_n = w + 2'd1;
        end else if (cnt == TIMEOUT_C) begin
          gnt_n     = 4'd0;
          ptr_n     = w + 2'd1;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      default: gnt_n = 4'd0;
    endcase
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - self-checking bench for reg_share_arbiter
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_reg_share_arbiter;

  localparam int TO = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  gnt, ack, q;
  logic        busy, timeout;

  int checks = 0;
  int errors = 0;

  reg_share_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner < 0 means free; phase 1 = granted awaiting write, 2 = holding.
  int         owner = -1;
  int         phase = 0;
  int         rr = 0;
  int         held = 0;
  logic [3:0] m_ack = 4'd0;
  logic [3:0] m_q = 4'd0;
  logic       m_to = 1'b0;

  function automatic logic [3:0] m_gnt();
    return (owner < 0) ? 4'd0 : 4'(1 << owner);
  endfunction

  task automatic model_edge();
    if (!reset) begin
      owner = -1; phase = 0; rr = 0; held = 0; m_ack = 0; m_q = 0; m_to = 0;
    end else if (owner < 0) begin
      m_ack = 0;
      for (int k = 0; k < 4; k++) begin
        if (owner < 0 && req[(rr + k) % 4]) owner = (rr + k) % 4;
      end
      phase = (owner < 0) ? 0 : 1;
    end else if (phase == 1) begin
      if (req[owner]) begin
        m_q = data_in[4*owner +: 4]; m_ack = 4'(1 << owner); held = 0; phase = 2;
      end else begin
        owner = -1; phase = 0;
      end
    end else begin
      m_ack = 0;
      if (!req[owner] || held == TO) begin
        if (req[owner]) m_to = 1'b1;
        rr = (owner + 1) % 4; owner = -1; phase = 0;
      end else begin
        held++;
      end
    end
  endtask

  task automatic tick(input logic [3:0] r, input logic [15:0] d);
    req = r; data_in = d;
    @(negedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(4'd0, 16'd0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(4'b1111, 16'hFFFF);
    tick(4'b1111, 16'hFFFF);
    checks++; if (gnt !== 4'd0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (ack !== 4'd0) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %h want 0", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    tick(4'b0001, 16'h000A);
    checks++; if (gnt !== 4'b0001 || ack !== 4'd0 || busy !== 1'b1) begin errors++;
      $display("FAIL basic_grant: got gnt=%b ack=%b busy=%b want 0001 0000 1", gnt, ack, busy); end
    tick(4'b0001, 16'h000A);
    checks++; if (q !== 4'hA || ack !== 4'b0001) begin errors++;
      $display("FAIL basic_write: got q=%h ack=%b want a 0001", q, ack); end
    tick(4'b0001, 16'h0003);
    checks++; if (ack !== 4'd0 || gnt !== 4'b0001 || q !== 4'hA) begin errors++;
      $display("FAIL basic_ack_pulse: got ack=%b gnt=%b q=%h want 0000 0001 a", ack, gnt, q); end
    tick(4'b0000, 16'h0003);
    checks++; if (gnt !== 4'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL basic_release: got gnt=%b busy=%b want 0000 0", gnt, busy); end
    tick(4'b1111, 16'h0000);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL basic_ptr: got %b want 0010", gnt); end
    tick(4'b0000, 16'h0000);
  endtask

  task automatic test_fairness();
    int         order[$];
    logic [3:0] prev_g = 4'd0;
    logic [3:0] drop = 4'd0;
    int         exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick(4'b1111 & ~drop, 16'($urandom));
      drop = 4'd0;
      if (gnt != 4'd0 && prev_g == 4'd0) begin
        for (int i = 0; i < 4; i++) if (gnt[i]) order.push_back(i);
      end
      if (ack != 4'd0) drop = ack;
      prev_g = gnt;
    end
    checks++; if (order.size() != 5) begin errors++;
      $display("FAIL fair_count: got %0d grants want 5", order.size()); end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      checks++; if (order[i] != exp_order[i]) begin errors++;
        $display("FAIL fair_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]); end
    end
    tick(4'd0, 16'd0);
    tick(4'd0, 16'd0);
  endtask

  task automatic test_abort();
    do_reset();
    tick(4'b0100, 16'h0F00);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_grant: got %b want 0100", gnt); end
    tick(4'b0000, 16'h0F00);
    checks++; if (gnt !== 4'd0 || ack !== 4'd0 || q !== 4'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_drop: got gnt=%b ack=%b q=%h busy=%b want 0000 0000 0 0", gnt, ack, q, busy); end
    tick(4'b1111, 16'h0000);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL abort_ptr: got %b want 0001", gnt); end
    tick(4'd0, 16'd0);
  endtask

  task automatic test_timeout();
    do_reset();
    tick(4'b0010, 16'h00C0);
    tick(4'b0010, 16'h00C0);
    checks++; if (ack !== 4'b0010 || q !== 4'hC) begin errors++;
      $display("FAIL to_write: got ack=%b q=%h want 0010 c", ack, q); end
    for (int i = 1; i <= 8; i++) begin
      tick(4'b0010, 16'h00C0);
      if (i == 7) begin
        checks++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin errors++;
          $display("FAIL to_hold7: got gnt=%b timeout=%b want 0010 0", gnt, timeout); end
      end
    end
    checks++; if (gnt !== 4'd0 || timeout !== 1'b1) begin errors++;
      $display("FAIL to_release: got gnt=%b timeout=%b want 0000 1", gnt, timeout); end
    tick(4'b1111, 16'h0000);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL to_ptr: got %b want 0100", gnt); end
    tick(4'd0, 16'd0);
    tick(4'd0, 16'd0);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeout); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    tick(4'b0001, 16'h0005);
    tick(4'b0001, 16'h0005);
    tick(4'b0001, 16'h0005);
    checks++; if (q !== 4'h5 || gnt !== 4'b0001) begin errors++;
      $display("FAIL rmh_pre: got q=%h gnt=%b want 5 0001", q, gnt); end
    reset = 1'b0;
    tick(4'b0001, 16'h0005);
    checks++; if (gnt !== 4'd0 || q !== 4'd0 || busy !== 1'b0 || ack !== 4'd0) begin errors++;
      $display("FAIL rmh_reset: got gnt=%b q=%h busy=%b ack=%b want 0000 0 0 0000", gnt, q, busy, ack); end
    reset = 1'b1;
    tick(4'b1111, 16'h0000);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmh_ptr: got %b want 0001", gnt); end
    tick(4'd0, 16'd0);
  endtask

  task automatic test_ignore_others();
    do_reset();
    tick(4'b1000, 16'h9000);
    tick(4'b1000, 16'h9000);
    checks++; if (q !== 4'h9 || ack !== 4'b1000) begin errors++;
      $display("FAIL ign_write: got q=%h ack=%b want 9 1000", q, ack); end
    for (int i = 0; i < 4; i++) begin
      tick(4'b1000 | 4'(i % 2), {4'h2, 8'h00, 4'(i + 3)});
      checks++; if (gnt !== 4'b1000 || q !== 4'h9) begin errors++;
        $display("FAIL ign_hold[%0d]: got gnt=%b q=%h want 1000 9", i, gnt, q); end
    end
    tick(4'd0, 16'd0);
    tick(4'd0, 16'd0);
  endtask

  task automatic test_random();
    logic [3:0] r = 4'd0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      tick(r, 16'($urandom));
      checks++; if (gnt !== m_gnt() || ack !== m_ack || q !== m_q || busy !== (owner >= 0) || timeout !== m_to) begin
        errors++;
        $display("FAIL rand[%0d]: got gnt=%b ack=%b q=%h busy=%b to=%b want %b %b %h %b %b",
                 c, gnt, ack, q, busy, timeout, m_gnt(), m_ack, m_q, owner >= 0, m_to);
      end
      checks++; if ($countones(gnt) > 1 || (ack != 4'd0 && ack !== gnt)) begin errors++;
        $display("FAIL rand_onehot[%0d]: got gnt=%b ack=%b want onehot gnt, ack 0 or gnt", c, gnt, ack); end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req = 4'd0; data_in = 16'd0;
    test_reset();
    test_basic();
    test_fairness();
    test_abort();
    test_timeout();
    test_reset_mid_hold();
    test_ignore_others();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
